exe_result_stage: RTL and testbench
===================================

# exe_result_stage

- Registered successor to the EXE-stage result select.
- Picks the writeback value per opcode and latches it into the EXE/MEM pipeline register, with valid, stall and flush.
- Owns the architectural interrupt flip-flops IFF1/IFF2, including the EI one-instruction delay, DI, RETN and interrupt-acknowledge effects.
- Sits between the EXE datapath (ALU, sequential-PC adder) and the MEM stage; `int_enable` feeds the interrupt controller.

## Interface
- `DATA_W`, 16, datapath width; minimum 2.
- `OPC_W`, 6, opcode width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  EXE holds a real instruction this cycle.
- `stall`  in  1  MEM not ready; hold all state.
- `flush`  in  1  kill the instruction in EXE.
- `opcode`  in  OPC_W  EXE instruction opcode.
- `imm`  in  2  mviff selector.
- `alu_result`  in  DATA_W  ALU output.
- `seq_npc`  in  DATA_W  sequential next PC.
- `nmi_ack`  in  1  NMI accepted this cycle.
- `int_ack`  in  1  maskable interrupt accepted this cycle.
- `out_valid`  out  1  EXE/MEM register holds a valid result.
- `result`  out  DATA_W  registered writeback value.
- `iff1`, `iff2`  out  1 each  interrupt flip-flops.
- `int_enable`  out  1  `iff1 & ~ei_pending`.

## Operation
- Retire event: `in_valid & ~stall & ~flush`.
- Result select (combinational, registered on retire):
  - OP_MVPC (6'h10): `seq_npc`.
  - OP_MVIFF (6'h1C): selected by `imm`, zero-extended to DATA_W:
    - 1 → `iff1`
    - 2 → `iff2`
    - 3 → `{iff2,iff1}` in bits [1:0]
    - 0 → 0
  - All other opcodes, including OP_EI/OP_DI/OP_RETN: `alu_result`.
- mviff reads the IFF values registered before the current edge. There is no bypass of same-cycle updates.
- IFF control, states encoded by {iff1, ei_pending}:
  - DISABLED: iff1=0, ei_pending=0.
  - PENDING: ei_pending=1.
  - ENABLED: iff1=1, ei_pending=0.
- Transitions on retire:
  - OP_EI (6'h1D): go to PENDING.
  - Any retire while PENDING (including a second EI): iff1=iff2=1, go to ENABLED. A repeated EI therefore does not re-extend the window.
  - OP_DI (6'h1E): iff1=iff2=0, go to DISABLED; this cancels a pending EI.
  - OP_RETN (6'h1F): iff1 takes iff2; ei_pending unchanged.
- Acknowledges (independent of stall and flush):
  - `nmi_ack`: iff1=0, iff2 held, ei_pending cleared.
  - `int_ack`: iff1=iff2=0, ei_pending cleared.
  - Both asserted together: `int_ack` behaviour.
- Priority for IFF state: reset > ack > retire effect.
  - An ack in the same cycle as a retire suppresses the instruction's IFF effect.
  - The instruction's `result`/`out_valid` still register.

## Timing
- Reset values: `out_valid`=0, `result`=0, `iff1`=0, `iff2`=0, ei_pending=0, so `int_enable`=0.
- Latency: one cycle, EXE inputs to `result`/`out_valid`.
- Stall: `result`, `out_valid` and IFF state all hold. `flush` is ignored while `stall` is high.
- Flush without stall:
  - `out_valid`=0 next cycle; `result` holds its old value.
  - No IFF effect from the flushed instruction; ei_pending untouched.
- Non-retire cycle without stall (`in_valid`=0): `out_valid`=0 next cycle.
- `int_enable` becomes 1 on the edge after the instruction following EI retires, never earlier.
- Reset asserted mid-stall or mid-PENDING: all state returns to reset values on that edge.

## Structure
- Shared package `exe_pkg`:
  - Opcode constants OP_MVPC, OP_MVIFF, OP_EI, OP_DI, OP_RETN.
  - Imm selector constants IFF_SEL_1/2/BOTH.
  - Parameter default DATA_W.
- Sub-module `iff_ctrl`:
  - Contains the IFF1/IFF2/ei_pending state and the ack-priority logic.
  - Inputs: retire strobe, decoded ei/di/retn, acks.
- The top level holds the result mux and the EXE/MEM register.

## Test plan
- Reset, then retire ALU op `alu_result`=16'hBEEF → next cycle `result`=16'hBEEF, `out_valid`=1. All IFF outputs 0 throughout.
- Retire EI, then mviff imm=1, then mviff imm=3 → results 0, then 16'h0003. `int_enable` goes 1 one cycle after the first mviff retires.
- Sequence ENABLED → `nmi_ack` → mviff imm=3 → 16'h0002. Then RETN → `iff1`=1 next cycle.
- EI retired, then DI retired next → `iff1`=`iff2`=0; `int_enable` never asserts.
- mvPC with `seq_npc`=16'h1234 while `stall` is high for 3 cycles → `result`/`out_valid` unchanged during the stall. `result`=16'h1234 one cycle after the stall drops.
- EI retired with `int_ack` in the same cycle → IFFs 0, ei_pending 0. `flush` on a DI leaves ENABLED state intact and gives `out_valid`=0.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the EXE result stage: opcodes, mviff selectors,
// default widths and the EI delay-window state type.
package exe_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned OPC_W_DEF  = 6;

    localparam logic [5:0] OP_MVPC  = 6'h10;
    localparam logic [5:0] OP_MVIFF = 6'h1C;
    localparam logic [5:0] OP_EI    = 6'h1D;
    localparam logic [5:0] OP_DI    = 6'h1E;
    localparam logic [5:0] OP_RETN  = 6'h1F;

    localparam logic [1:0] IFF_SEL_1    = 2'd1;
    localparam logic [1:0] IFF_SEL_2    = 2'd2;
    localparam logic [1:0] IFF_SEL_BOTH = 2'd3;

    typedef enum logic {
        EI_IDLE,
        EI_PENDING
    } ei_state_e;

endpackage

// File: rtl/exe_result_stage_if.sv
// EXE -> EXE/MEM bus: instruction inputs from EXE and the registered
// result back out. master = EXE side, slave = result stage.
interface exe_result_stage_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OPC_W  = 6
);
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic [OPC_W-1:0]  opcode;
    logic [1:0]        imm;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] seq_npc;
    logic              out_valid;
    logic [DATA_W-1:0] result;

    modport master (
        output in_valid, stall, flush, opcode, imm, alu_result, seq_npc,
        input  out_valid, result
    );

    modport slave (
        input  in_valid, stall, flush, opcode, imm, alu_result, seq_npc,
        output out_valid, result
    );
endinterface

// File: rtl/exe_result_stage_iff_ctrl.sv
// Architectural IFF1/IFF2 flip-flops with the EI one-instruction delay
// window; acknowledges override any retiring instruction's effect.
module iff_ctrl
    import exe_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic retire,
    input  logic is_ei,
    input  logic is_di,
    input  logic is_retn,
    input  logic nmi_ack,
    input  logic int_ack,
    output logic iff1,
    output logic iff2,
    output logic ei_pending
);

    ei_state_e state_q, state_d;
    logic      iff1_q, iff1_d;
    logic      iff2_q, iff2_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EI_IDLE;
            iff1_q  <= 1'b0;
            iff2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iff1_q  <= iff1_d;
            iff2_q  <= iff2_d;
        end
    end

    // DI beats completion of a pending EI; completion beats a fresh EI so
    // a repeated EI does not re-extend the window.
    always_comb begin
        state_d = state_q;
        iff1_d  = iff1_q;
        iff2_d  = iff2_q;
        if (int_ack) begin
            state_d = EI_IDLE;
            iff1_d  = 1'b0;
            iff2_d  = 1'b0;
        end else if (nmi_ack) begin
            state_d = EI_IDLE;
            iff1_d  = 1'b0;
        end else if (retire) begin
            if (is_di) begin
                state_d = EI_IDLE;
                iff1_d  = 1'b0;
                iff2_d  = 1'b0;
            end else if (state_q == EI_PENDING) begin
                state_d = EI_IDLE;
                iff1_d  = 1'b1;
                iff2_d  = 1'b1;
            end else if (is_ei) begin
                state_d = EI_PENDING;
            end else if (is_retn) begin
                iff1_d  = iff2_q;
            end
        end
    end

    assign iff1       = iff1_q;
    assign iff2       = iff2_q;
    assign ei_pending = (state_q == EI_PENDING);

endmodule

// File: rtl/exe_result_stage.sv
// EXE result select and EXE/MEM pipeline register; owns the interrupt
// flip-flops through iff_ctrl.
module exe_result_stage
    import exe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned OPC_W  = OPC_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    exe_result_stage_if.slave   bus,
    input  logic                nmi_ack,
    input  logic                int_ack,
    output logic                iff1,
    output logic                iff2,
    output logic                int_enable
);

    logic              retire;
    logic              ei_pending;
    logic [OPC_W-1:0]  opc;
    logic [DATA_W-1:0] result_sel;
    logic [DATA_W-1:0] result_q;
    logic              out_valid_q;

    assign opc    = bus.opcode;
    assign retire = bus.in_valid & ~bus.stall & ~bus.flush;

    // mviff reads the IFF values registered before this edge (no bypass).
    always_comb begin
        result_sel = bus.alu_result;
        if (opc == OP_MVPC) begin
            result_sel = bus.seq_npc;
        end else if (opc == OP_MVIFF) begin
            result_sel = '0;
            case (bus.imm)
                IFF_SEL_1:    result_sel[0]   = iff1;
                IFF_SEL_2:    result_sel[0]   = iff2;
                IFF_SEL_BOTH: result_sel[1:0] = {iff2, iff1};
                default:      result_sel      = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (!bus.stall) begin
            out_valid_q <= retire;
            if (retire) begin
                result_q <= result_sel;
            end
        end
    end

    iff_ctrl u_iff_ctrl (
        .clk        (clk),
        .reset      (reset),
        .retire     (retire),
        .is_ei      (opc == OP_EI),
        .is_di      (opc == OP_DI),
        .is_retn    (opc == OP_RETN),
        .nmi_ack    (nmi_ack),
        .int_ack    (int_ack),
        .iff1       (iff1),
        .iff2       (iff2),
        .ei_pending (ei_pending)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign int_enable    = iff1 & ~ei_pending;

endmodule

// File: tb/tb_exe_result_stage.sv
// Directed bench for exe_result_stage: one task per scenario with
// hand-computed expectations.
module tb_exe_result_stage;

    logic clk = 1'b0;
    logic reset;
    logic nmi_ack, int_ack;
    logic iff1, iff2, int_enable;
    int   total = 0;
    int   bad   = 0;

    exe_result_stage_if #(.DATA_W(16), .OPC_W(6)) bus ();

    exe_result_stage #(.DATA_W(16), .OPC_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .nmi_ack    (nmi_ack),
        .int_ack    (int_ack),
        .iff1       (iff1),
        .iff2       (iff2),
        .int_enable (int_enable)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [1:0] im,
                         input logic [15:0] alu, input logic [15:0] npc);
        bus.in_valid   = v;
        bus.opcode     = op;
        bus.imm        = im;
        bus.alu_result = alu;
        bus.seq_npc    = npc;
    endtask

    task automatic test_reset();
        reset = 1'b1; nmi_ack = 1'b0; int_ack = 1'b0;
        bus.stall = 1'b0; bus.flush = 1'b0;
        drive(1'b0, 6'h00, 2'd0, 16'h0000, 16'h0000);
        step(); step();
        reset = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.result !== 16'h0000) begin bad++; $display("FAIL reset_result: got %h want 0000", bus.result); end
        total++; if ({iff1, iff2, int_enable} !== 3'b000) begin bad++; $display("FAIL reset_iff: got %b want 000", {iff1, iff2, int_enable}); end
    endtask

    task automatic test_alu();
        drive(1'b1, 6'h00, 2'd0, 16'hBEEF, 16'h0000);
        step();
        total++; if (bus.result !== 16'hBEEF) begin bad++; $display("FAIL alu_result: got %h want beef", bus.result); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL alu_valid: got %b want 1", bus.out_valid); end
        total++; if ({iff1, iff2, int_enable} !== 3'b000) begin bad++; $display("FAIL alu_iff: got %b want 000", {iff1, iff2, int_enable}); end
        drive(1'b0, 6'h00, 2'd0, 16'h1111, 16'h0000);
        step();
        total++; if ({bus.out_valid, bus.result} !== {1'b0, 16'hBEEF}) begin bad++; $display("FAIL idle_hold: got %b/%h want 0/beef", bus.out_valid, bus.result); end
    endtask

    task automatic test_ei_mviff();
        drive(1'b1, 6'h1D, 2'd0, 16'h5555, 16'h0000);
        step();
        total++; if (bus.result !== 16'h5555) begin bad++; $display("FAIL ei_result: got %h want 5555", bus.result); end
        total++; if ({iff1, int_enable} !== 2'b00) begin bad++; $display("FAIL ei_pending_window: got %b want 00", {iff1, int_enable}); end
        drive(1'b1, 6'h1C, 2'd1, 16'hFFFF, 16'h0000);
        step();
        total++; if (bus.result !== 16'h0000) begin bad++; $display("FAIL mviff1_old: got %h want 0000", bus.result); end
        total++; if ({iff1, iff2, int_enable} !== 3'b111) begin bad++; $display("FAIL ei_enabled: got %b want 111", {iff1, iff2, int_enable}); end
        drive(1'b1, 6'h1C, 2'd3, 16'hFFFF, 16'h0000);
        step();
        total++; if (bus.result !== 16'h0003) begin bad++; $display("FAIL mviff3: got %h want 0003", bus.result); end
        drive(1'b1, 6'h1C, 2'd0, 16'hFFFF, 16'h0000);
        step();
        total++; if (bus.result !== 16'h0000) begin bad++; $display("FAIL mviff0: got %h want 0000", bus.result); end
    endtask

    task automatic test_nmi_retn();
        drive(1'b0, 6'h00, 2'd0, 16'h0000, 16'h0000);
        nmi_ack = 1'b1;
        step();
        nmi_ack = 1'b0;
        total++; if ({iff1, iff2, int_enable} !== 3'b010) begin bad++; $display("FAIL nmi_ack: got %b want 010", {iff1, iff2, int_enable}); end
        drive(1'b1, 6'h1C, 2'd3, 16'hFFFF, 16'h0000);
        step();
        total++; if (bus.result !== 16'h0002) begin bad++; $display("FAIL nmi_mviff3: got %h want 0002", bus.result); end
        drive(1'b1, 6'h1C, 2'd2, 16'hFFFF, 16'h0000);
        step();
        total++; if (bus.result !== 16'h0001) begin bad++; $display("FAIL mviff2: got %h want 0001", bus.result); end
        drive(1'b1, 6'h1F, 2'd0, 16'h00AA, 16'h0000);
        step();
        total++; if ({iff1, iff2, int_enable} !== 3'b111) begin bad++; $display("FAIL retn: got %b want 111", {iff1, iff2, int_enable}); end
        total++; if (bus.result !== 16'h00AA) begin bad++; $display("FAIL retn_result: got %h want 00aa", bus.result); end
        drive(1'b0, 6'h00, 2'd0, 16'h0000, 16'h0000);
        nmi_ack = 1'b1; int_ack = 1'b1;
        step();
        nmi_ack = 1'b0; int_ack = 1'b0;
        total++; if ({iff1, iff2} !== 2'b00) begin bad++; $display("FAIL both_acks: got %b want 00", {iff1, iff2}); end
    endtask

    task automatic test_ei_di();
        drive(1'b1, 6'h1D, 2'd0, 16'h0000, 16'h0000);
        step();
        drive(1'b1, 6'h1E, 2'd0, 16'h0000, 16'h0000);
        step();
        total++; if ({iff1, iff2, int_enable} !== 3'b000) begin bad++; $display("FAIL ei_di: got %b want 000", {iff1, iff2, int_enable}); end
        drive(1'b1, 6'h00, 2'd0, 16'h7777, 16'h0000);
        step();
        total++; if ({iff1, iff2, int_enable} !== 3'b000) begin bad++; $display("FAIL ei_di_cancel: got %b want 000", {iff1, iff2, int_enable}); end
    endtask

    task automatic test_stall();
        drive(1'b1, 6'h10, 2'd0, 16'hFFFF, 16'h1234);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.flush = (i == 1);
            step();
            total++; if ({bus.out_valid, bus.result} !== {1'b1, 16'h7777}) begin bad++; $display("FAIL stall_hold%0d: got %b/%h want 1/7777", i, bus.out_valid, bus.result); end
        end
        bus.stall = 1'b0; bus.flush = 1'b0;
        step();
        total++; if ({bus.out_valid, bus.result} !== {1'b1, 16'h1234}) begin bad++; $display("FAIL stall_release: got %b/%h want 1/1234", bus.out_valid, bus.result); end
    endtask

    task automatic test_ack_same_cycle();
        drive(1'b1, 6'h1D, 2'd0, 16'h4321, 16'h0000);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        total++; if ({bus.out_valid, bus.result} !== {1'b1, 16'h4321}) begin bad++; $display("FAIL ack_ei_result: got %b/%h want 1/4321", bus.out_valid, bus.result); end
        drive(1'b1, 6'h00, 2'd0, 16'h0000, 16'h0000);
        step();
        total++; if ({iff1, iff2, int_enable} !== 3'b000) begin bad++; $display("FAIL ack_ei_suppressed: got %b want 000", {iff1, iff2, int_enable}); end
    endtask

    task automatic test_flush();
        drive(1'b1, 6'h1D, 2'd0, 16'h0000, 16'h0000);
        step();
        drive(1'b1, 6'h00, 2'd0, 16'h2468, 16'h0000);
        step();
        total++; if ({iff1, iff2, int_enable} !== 3'b111) begin bad++; $display("FAIL flush_setup: got %b want 111", {iff1, iff2, int_enable}); end
        drive(1'b1, 6'h1E, 2'd0, 16'h9999, 16'h0000);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        total++; if ({bus.out_valid, bus.result} !== {1'b0, 16'h2468}) begin bad++; $display("FAIL flush_di_out: got %b/%h want 0/2468", bus.out_valid, bus.result); end
        total++; if ({iff1, iff2, int_enable} !== 3'b111) begin bad++; $display("FAIL flush_di_iff: got %b want 111", {iff1, iff2, int_enable}); end
        drive(1'b1, 6'h1D, 2'd0, 16'h0000, 16'h0000);
        step();
        drive(1'b1, 6'h00, 2'd0, 16'h0000, 16'h0000);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        total++; if (int_enable !== 1'b0) begin bad++; $display("FAIL flush_keeps_pending: got %b want 0", int_enable); end
        step();
        total++; if (int_enable !== 1'b1) begin bad++; $display("FAIL pending_complete: got %b want 1", int_enable); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 6'h1D, 2'd0, 16'h0000, 16'h0000);
        step();
        bus.stall = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0; bus.stall = 1'b0;
        drive(1'b0, 6'h00, 2'd0, 16'h0000, 16'h0000);
        total++; if ({bus.out_valid, bus.result, iff1, iff2, int_enable} !== {1'b0, 16'h0000, 3'b000}) begin bad++; $display("FAIL reset_mid: got %b/%h/%b want 0/0000/000", bus.out_valid, bus.result, {iff1, iff2, int_enable}); end
        step();
        total++; if ({iff1, int_enable} !== 2'b00) begin bad++; $display("FAIL reset_mid_pending: got %b want 00", {iff1, int_enable}); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ei_mviff();
        test_nmi_retn();
        test_ei_di();
        test_stall();
        test_ack_same_cycle();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
